// File: rtl/spi_target.sv
// spi_target: SPI peripheral endpoint oversampled on clk; bytes MSbit first, words LSByte first
// Ports:
//   clk, rst                       system clock, async active-high reset
//   spi_cs_n, spi_sclk, spi_mosi   async SPI pins (synchronised inside)
//   spi_miso, spi_miso_oe          target data out and its enable while selected
//   wordsize                       1 = 32-bit words, 0 = bytes; latched at frame start
//   tx_data, tx_wr, tx_full        tx holding register write port and occupancy
//   tx_underrun                    pulse when a word starts with the holding register empty
//   rx_data, rx_valid              last completed word and its update pulse
//   busy                           frame in progress
module spi_target (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_cs_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic        wordsize,
    input  logic [31:0] tx_data,
    input  logic        tx_wr,
    output logic        tx_full,
    output logic        tx_underrun,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        busy
);
    typedef enum logic {S_IDLE, S_ACTIVE} state_t;
    state_t      r_state, w_state_next;
    logic [1:0]  r_cs_s, r_sclk_s, r_mosi_s;
    logic        r_cs_d, r_sclk_d;
    logic        r_ws, r_rose, r_full, r_underrun, r_rx_valid, r_miso, r_oe;
    logic [4:0]  r_cnt;
    logic [31:0] r_tx_sh, r_rx_sh, r_hold, r_rx_data;
    logic        w_start, w_end, w_act, w_rise, w_fall, w_last, w_load;
    logic [4:0]  w_pos;
    logic [31:0] w_load_word, w_rx_next;

    assign w_start     = (r_state == S_IDLE) & r_cs_d & ~r_cs_s[1];
    assign w_end       = (r_state == S_ACTIVE) & ~r_cs_d & r_cs_s[1];
    assign w_act       = (r_state == S_ACTIVE) & ~w_end;
    assign w_rise      = w_act & ~r_sclk_d & r_sclk_s[1];
    // only a falling edge that follows a rising edge advances miso
    assign w_fall      = w_act & r_sclk_d & ~r_sclk_s[1] & r_rose;
    assign w_last      = r_cnt == (r_ws ? 5'd31 : 5'd7);
    // bit index -> data position: bytes ascend, bits within a byte descend
    assign w_pos       = {r_cnt[4:3], ~r_cnt[2:0]};
    // counter already wrapped to 0 means this falling edge begins a new word
    assign w_load      = w_start | (w_fall & (r_cnt == 5'd0));
    assign w_load_word = r_full ? r_hold : (tx_wr ? tx_data : 32'hFFFF_FFFF);
    assign w_state_next = (r_state == S_IDLE) ? (w_start ? S_ACTIVE : S_IDLE)
                                              : (w_end ? S_IDLE : S_ACTIVE);

    always_comb begin
        w_rx_next = r_rx_sh;
        w_rx_next[w_pos] = r_mosi_s[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_s     <= 2'b11;
            r_sclk_s   <= 2'b11;
            r_mosi_s   <= 2'b11;
            r_cs_d     <= 1'b1;
            r_sclk_d   <= 1'b1;
            r_ws       <= 1'b0;
            r_rose     <= 1'b0;
            r_full     <= 1'b0;
            r_underrun <= 1'b0;
            r_rx_valid <= 1'b0;
            r_miso     <= 1'b1;
            r_oe       <= 1'b0;
            r_cnt      <= 5'd0;
            r_tx_sh    <= 32'd0;
            r_rx_sh    <= 32'd0;
            r_hold     <= 32'd0;
            r_rx_data  <= 32'd0;
        end else begin
            r_cs_s     <= {r_cs_s[0], spi_cs_n};
            r_sclk_s   <= {r_sclk_s[0], spi_sclk};
            r_mosi_s   <= {r_mosi_s[0], spi_mosi};
            r_cs_d     <= r_cs_s[1];
            r_sclk_d   <= r_sclk_s[1];
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
            // a write lands in holding when it is free, or when a load vacates it this cycle
            if (tx_wr && (w_load == r_full)) r_hold <= tx_data;
            r_full <= w_load ? (r_full & tx_wr) : (r_full | tx_wr);
            if (w_load) begin
                r_tx_sh    <= w_load_word;
                r_underrun <= ~r_full & ~tx_wr;
            end
            if (w_start) begin
                r_ws   <= wordsize;
                r_cnt  <= 5'd0;
                r_rose <= 1'b0;
                r_oe   <= 1'b1;
                r_miso <= w_load_word[7];
            end
            if (w_end) begin
                r_oe   <= 1'b0;
                r_miso <= 1'b1;
            end
            if (w_rise) begin
                r_rx_sh <= w_rx_next;
                r_rose  <= 1'b1;
                r_cnt   <= w_last ? 5'd0 : r_cnt + 5'd1;
                if (w_last) begin
                    r_rx_data  <= r_ws ? w_rx_next : {24'd0, w_rx_next[7:0]};
                    r_rx_valid <= 1'b1;
                end
            end
            if (w_fall) begin
                r_rose <= 1'b0;
                r_miso <= (r_cnt == 5'd0) ? w_load_word[7] : r_tx_sh[w_pos];
            end
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_oe;
    assign tx_full     = r_full;
    assign tx_underrun = r_underrun;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign busy        = r_state == S_ACTIVE;
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed self-checking bench for spi_target
module tb_spi_target;
    localparam int H = 6;
    logic        clk, rst, spi_cs_n, spi_sclk, spi_mosi, spi_miso, spi_miso_oe;
    logic        wordsize, tx_wr, tx_full, tx_underrun, rx_valid, busy;
    logic [31:0] tx_data, rx_data, mi, mi2;
    int          checks, failures, rv_cnt, ur_cnt;

    spi_target dut (
        .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .wordsize(wordsize), .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full),
        .tx_underrun(tx_underrun), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) rv_cnt++;
        if (tx_underrun) ur_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic int pos(input int i);
        return 8 * (i / 8) + 7 - (i % 8);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] d);
        @(posedge clk); #1;
        tx_data = d;
        tx_wr = 1'b1;
        @(posedge clk); #1;
        tx_wr = 1'b0;
    endtask

    task automatic sel();
        spi_cs_n = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic desel();
        repeat (4) @(posedge clk);
        #1 spi_cs_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int n, input logic [31:0] mo, output logic [31:0] mr);
        mr = 32'd0;
        for (int i = 0; i < n; i++) begin
            spi_sclk = 1'b0;
            spi_mosi = mo[pos(i)];
            repeat (H) @(posedge clk);
            #1 mr[pos(i)] = spi_miso;
            spi_sclk = 1'b1;
            repeat (H) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0; failures = 0; rv_cnt = 0; ur_cnt = 0;
        rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b1; spi_mosi = 1'b1;
        wordsize = 1'b0; tx_wr = 1'b0; tx_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_miso", spi_miso, 1);
        chk("rst_oe", spi_miso_oe, 0);
        chk("rst_full", tx_full, 0);
        chk("rst_underrun", tx_underrun, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        wordsize = 1'b0;
        wr(32'h0000_00A5);
        chk("byte_full_before", tx_full, 1);
        sel();
        chk("byte_busy", busy, 1);
        chk("byte_oe", spi_miso_oe, 1);
        chk("byte_full_after", tx_full, 0);
        chk("byte_first_bit", spi_miso, 1);
        xfer(8, 32'h0000_003C, mi);
        chk("byte_miso", mi, 32'h0000_00A5);
        desel();
        chk("byte_rx", rx_data, 32'h0000_003C);
        chk("byte_rv", rv_cnt, 1);
        chk("byte_end_oe", spi_miso_oe, 0);
        chk("byte_end_busy", busy, 0);
        chk("byte_end_miso", spi_miso, 1);

        wordsize = 1'b1;
        wr(32'h1234_5678);
        sel();
        wordsize = 1'b0;
        xfer(32, 32'hCAFE_BABE, mi);
        chk("word_miso", mi, 32'h1234_5678);
        desel();
        chk("word_rx", rx_data, 32'hCAFE_BABE);
        chk("word_rv", rv_cnt, 2);

        wordsize = 1'b1;
        wr(32'hAAAA_5555);
        sel();
        fork
            xfer(32, 32'h0F1E_2D3C, mi);
            begin
                repeat (60) @(posedge clk);
                #1 tx_data = 32'h1111_1111;
                tx_wr = 1'b1;
                @(posedge clk);
                #1 tx_wr = 1'b0;
            end
        join
        chk("b2b_miso1", mi, 32'hAAAA_5555);
        chk("b2b_rx1", rx_data, 32'h0F1E_2D3C);
        chk("b2b_full_mid", tx_full, 1);
        xfer(32, 32'hDEAD_BEEF, mi2);
        chk("b2b_miso2", mi2, 32'h1111_1111);
        desel();
        chk("b2b_rx2", rx_data, 32'hDEAD_BEEF);
        chk("b2b_rv", rv_cnt, 4);
        chk("b2b_full_end", tx_full, 0);
        chk("b2b_no_underrun", ur_cnt, 0);

        wordsize = 1'b0;
        wr(32'h0000_005A);
        sel();
        xfer(8, 32'h0000_0081, mi);
        chk("ur_miso1", mi, 32'h0000_005A);
        chk("ur_none_yet", ur_cnt, 0);
        xfer(8, 32'h0000_007E, mi);
        chk("ur_miso2", mi, 32'h0000_00FF);
        chk("ur_pulse", ur_cnt, 1);
        desel();
        chk("ur_rx", rx_data, 32'h0000_007E);
        chk("ur_rv", rv_cnt, 6);

        wr(32'h0000_00C3);
        sel();
        xfer(5, 32'h0000_00FF, mi);
        chk("abort_miso", mi, 32'h0000_00C0);
        repeat (2) @(posedge clk);
        #1 spi_cs_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_oe", spi_miso_oe, 0);
        chk("abort_busy", busy, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_rv", rv_cnt, 6);
        chk("abort_rx_hold", rx_data, 32'h0000_007E);
        chk("abort_full", tx_full, 0);
        wr(32'h0000_0096);
        sel();
        xfer(8, 32'h0000_005B, mi);
        chk("post_abort_miso", mi, 32'h0000_0096);
        desel();
        chk("post_abort_rx", rx_data, 32'h0000_005B);
        chk("post_abort_rv", rv_cnt, 7);

        wordsize = 1'b1;
        wr(32'hCAFE_F00D);
        sel();
        xfer(12, 32'hFFFF_FFFF, mi);
        spi_sclk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        wr(32'h0BAD_CAFE);
        chk("mid_full_pre", tx_full, 1);
        chk("mid_busy_pre", busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_miso", spi_miso, 1);
        chk("mid_rst_oe", spi_miso_oe, 0);
        chk("mid_rst_full", tx_full, 0);
        chk("mid_rst_underrun", tx_underrun, 0);
        chk("mid_rst_rx_data", rx_data, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_busy", busy, 0);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("after_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
